audio_i2s_rx: RTL

AUDIO_I2S_RX -- requirements
Module: audio_i2s_rx

---
 rtl/audio_i2s_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/audio_i2s_rx.sv
// audio_i2s_rx: I2S receiver that oversamples bclk/lrclk/sdata on clk and emits stereo pairs.
// Also flags framing errors and drops lock when bclk stops.
module audio_i2s_rx #(
    parameter int DATA_W    = 16,
    parameter int TO_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lrclk,
    input  logic                   i2s_sdata,
    input  logic                   err_clr,
    output logic [1:0][DATA_W-1:0] audio_out,
    output logic                   sample_valid,
    output logic                   locked,
    output logic                   frame_err
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {INIT, HUNT, SHIFT, WAIT} state_t;

    state_t                 state, state_n;
    logic [2:0]             bclk_q, lr_q, sd_q;
    logic                   lr_prev, lr_prev_n, chan, chan_n, left_ok, left_ok_n;
    logic                   locked_n, frame_err_n, valid_n;
    logic [CW-1:0]          bit_cnt, bit_cnt_n;
    logic [TW-1:0]          to_cnt;
    logic [DATA_W-1:0]      shreg, shreg_n, word;
    logic [1:0][DATA_W-1:0] hold, hold_n, audio_n;
    logic                   brise, lr, sd, to_hit, lr_edge, last_bit;

    // lrclk/sdata are taken from their history stage: the value present just before the bclk rise
    assign brise    = bclk_q[1] & ~bclk_q[2];
    assign lr       = lr_q[2];
    assign sd       = sd_q[2];
    assign to_hit   = to_cnt == TW'(TO_CYCLES);
    assign lr_edge  = lr != lr_prev;
    assign last_bit = bit_cnt == CW'(DATA_W - 1);
    assign word     = {shreg[DATA_W-2:0], sd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_q       <= '0;
            lr_q         <= '0;
            sd_q         <= '0;
            to_cnt       <= '0;
            state        <= INIT;
            lr_prev      <= 1'b0;
            chan         <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            hold         <= '0;
            audio_out    <= '0;
            left_ok      <= 1'b0;
            locked       <= 1'b0;
            frame_err    <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            bclk_q       <= {bclk_q[1:0], i2s_bclk};
            lr_q         <= {lr_q[1:0], i2s_lrclk};
            sd_q         <= {sd_q[1:0], i2s_sdata};
            to_cnt       <= brise ? '0 : to_hit ? to_cnt : to_cnt + 1'b1;
            state        <= state_n;
            lr_prev      <= lr_prev_n;
            chan         <= chan_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            hold         <= hold_n;
            audio_out    <= audio_n;
            left_ok      <= left_ok_n;
            locked       <= locked_n;
            frame_err    <= frame_err_n;
            sample_valid <= valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        lr_prev_n   = lr_prev;
        chan_n      = chan;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        hold_n      = hold;
        audio_n     = audio_out;
        left_ok_n   = left_ok;
        locked_n    = locked;
        valid_n     = 1'b0;
        frame_err_n = frame_err & ~err_clr;
        if (to_hit) begin
            state_n   = INIT;
            locked_n  = 1'b0;
            left_ok_n = 1'b0;
        end else if (brise) begin
            lr_prev_n = lr;
            case (state)
                INIT: state_n = HUNT;
                HUNT, WAIT: begin
                    if (lr_edge) begin
                        state_n   = SHIFT;
                        bit_cnt_n = '0;
                        chan_n    = lr;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        frame_err_n = 1'b1;
                        left_ok_n   = 1'b0;
                        locked_n    = 1'b0;
                        bit_cnt_n   = '0;
                        chan_n      = lr;
                    end else begin
                        shreg_n   = word;
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (last_bit) begin
                            state_n      = WAIT;
                            hold_n[chan] = word;
                            if (!chan) begin
                                left_ok_n = 1'b1;
                            end else if (left_ok) begin
                                audio_n   = {word, hold[0]};
                                valid_n   = 1'b1;
                                locked_n  = 1'b1;
                                left_ok_n = 1'b0;
                            end else begin
                                frame_err_n = 1'b1;
                            end
                        end
                    end
                end
                default: state_n = INIT;
            endcase
        end
    end
endmodule
